// File: rtl/mem_stage.sv
// Memory-access stage: registers the execute bus, waits for the load response, and aligns/extends load data.
// Optional LWL/LWR merge support is enabled by defining MS_LWLR_EN.
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ws_allowin,
  output logic         ms_allowin,
  input  logic         es_to_ms_valid,
  input  logic [105:0] es_to_ms_bus,
  output logic         ms_to_ws_valid,
  output logic [69:0]  ms_to_ws_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic         ms_valid,
  output logic [4:0]   ms_rf_waddr,
  output logic [31:0]  ms_rf_wdata,
  output logic         ms_load_wait
);

  logic         ms_valid_q, ms_valid_d;
  logic [105:0] bus_q, bus_d;
  logic         buf_valid_q, buf_valid_d;
  logic [31:0]  buf_data_q, buf_data_d;

  logic [31:0] pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic        is_load;
  logic [2:0]  ld_type;
  logic [1:0]  off;
  logic        ms_ready_go;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_result;
  logic [31:0] rf_wdata;

  assign pc         = bus_q[105:74];
  assign rf_we      = bus_q[73];
  assign rf_waddr   = bus_q[72:68];
  assign alu_result = bus_q[67:36];
  assign is_load    = bus_q[3];
  assign ld_type    = bus_q[2:0];
  assign off        = alu_result[1:0];

`ifdef MS_LWLR_EN
  logic [31:0] rt_value;
  assign rt_value = bus_q[35:4];

  function automatic logic [31:0] lwl_merge(input logic [31:0] rd, input logic [31:0] rt,
                                            input logic [1:0] o);
    case (o)
      2'd0:    lwl_merge = {rd[7:0], rt[23:0]};
      2'd1:    lwl_merge = {rd[15:0], rt[15:0]};
      2'd2:    lwl_merge = {rd[23:0], rt[7:0]};
      default: lwl_merge = rd;
    endcase
  endfunction

  function automatic logic [31:0] lwr_merge(input logic [31:0] rd, input logic [31:0] rt,
                                            input logic [1:0] o);
    case (o)
      2'd0:    lwr_merge = rd;
      2'd1:    lwr_merge = {rt[31:24], rd[31:8]};
      2'd2:    lwr_merge = {rt[31:16], rd[31:16]};
      default: lwr_merge = {rt[31:8], rd[31:24]};
    endcase
  endfunction
`else
  logic [31:0] unused_rt_value;
  assign unused_rt_value = bus_q[35:4];
`endif

  // A buffered response wins; otherwise the live SRAM data is used in its data_ok cycle.
  assign ms_ready_go    = !is_load || data_sram_data_ok || buf_valid_q;
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ld_data        = buf_valid_q ? buf_data_q : data_sram_rdata;

  assign ms_valid     = ms_valid_q;
  assign ms_load_wait = ms_valid_q && is_load && !ms_ready_go;
  assign ms_rf_waddr  = rf_we ? rf_waddr : 5'd0;
  assign ms_rf_wdata  = rf_wdata;
  assign ms_to_ws_bus = {pc, rf_we, rf_waddr, rf_wdata};

  // Little-endian byte/half selection and load-type extension.
  always_comb begin
    ld_byte     = 8'd0;
    ld_half     = 16'd0;
    load_result = ld_data;
    case (off)
      2'd0:    ld_byte = ld_data[7:0];
      2'd1:    ld_byte = ld_data[15:8];
      2'd2:    ld_byte = ld_data[23:16];
      default: ld_byte = ld_data[31:24];
    endcase
    if (off[1]) begin
      ld_half = ld_data[31:16];
    end else begin
      ld_half = ld_data[15:0];
    end
    case (ld_type)
      3'b001:  load_result = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_result = {24'd0, ld_byte};
      3'b011:  load_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_result = {16'd0, ld_half};
`ifdef MS_LWLR_EN
      3'b101:  load_result = lwl_merge(ld_data, rt_value, off);
      3'b110:  load_result = lwr_merge(ld_data, rt_value, off);
`endif
      default: load_result = ld_data;
    endcase
    if (is_load) begin
      rf_wdata = load_result;
    end else begin
      rf_wdata = alu_result;
    end
  end

  // Next-state for the valid flag, bus register and response buffer (clear beats capture).
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end else begin
      ms_valid_d = ms_valid_q;
    end
    if (ms_allowin && es_to_ms_valid) begin
      bus_d = es_to_ms_bus;
    end else begin
      bus_d = bus_q;
    end
    if (ms_to_ws_valid && ws_allowin) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q && is_load && data_sram_data_ok && !buf_valid_q && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= 106'd0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'd0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule
